string_detector_param: RTL and testbench

- Parametrised serial bit-pattern detector; successor to the fixed 4-bit, single-mode string detector.
- Watches a 1-bit serial stream and counts occurrences of a runtime-loadable pattern of 1..PAT_W bits.
- Supports overlapping and non-overlapping match modes, input qualification, saturating count and a per-match pulse.
- Sits between a serial front end and status/counter logic.

---
 rtl/string_det_pkg.sv | 17 +
 rtl/sat_counter.sv | 29 ++
 rtl/string_detector_param.sv | 96 +++++++++
 tb/tb_string_detector_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/string_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package string_det_pkg;

    localparam logic MODE_OVERLAP    = 1'b0;
    localparam logic MODE_NONOVERLAP = 1'b1;

    // Widest pattern the compare-mask helper can describe.
    localparam int MAX_PAT_W = 32;

    // Mask with the low 'len' bits set; callers truncate to their own width.
    function automatic logic [MAX_PAT_W-1:0] len_mask(input logic [31:0] len);
        if (len >= 32'(MAX_PAT_W))
            return '1;
        return (32'd1 << len) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky overflow flag.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    // Count up to all-ones; a further increment only raises sat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc) begin
            if (cnt == '1)
                sat <= 1'b1;
            else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/string_detector_param.sv
// Serial bit-pattern detector with runtime-loadable pattern, length and
// overlap mode; counts matches and pulses 'match' on each completion.
module string_detector_param
    import string_det_pkg::*;
#(
    parameter  int PAT_W = 8,
    parameter  int CNT_W = 4,
    localparam int LEN_W = $clog2(PAT_W+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_mode,
    input  logic             in_valid,
    input  logic             din,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] N,
    output logic             sat,
    output logic             cfg_err
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    logic [PAT_W-1:0] window, pattern_q, nwin, mask;
    logic [LEN_W-1:0] seen, nseen, len_q;
    logic             mode_q, accept, hit, len_bad, cnt_inc;

    // A config load swallows the data bit of the same cycle.
    assign accept  = in_valid & ~cfg_load;
    assign nwin    = {window[PAT_W-2:0], din};
    assign nseen   = (seen == LEN_MAX) ? seen : seen + 1'b1;
    assign mask    = PAT_W'(len_mask(32'(len_q)));
    // Only the low len_q bits matter; older window bits are stale.
    assign hit     = (nseen >= len_q) && (((nwin ^ pattern_q) & mask) == '0);
    assign len_bad = (cfg_len == '0) || (cfg_len > LEN_MAX);
    // clr drops the hit of a bit accepted in the same cycle.
    assign cnt_inc = accept & hit & ~clr;

    // Capture configuration; an illegal length falls back to full width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
            len_q     <= LEN_MAX;
            mode_q    <= MODE_OVERLAP;
            cfg_err   <= 1'b0;
        end else if (cfg_load) begin
            pattern_q <= cfg_pattern;
            mode_q    <= cfg_mode;
            if (len_bad) begin
                len_q   <= LEN_MAX;
                cfg_err <= 1'b1;
            end else begin
                len_q   <= cfg_len;
                cfg_err <= 1'b0;
            end
        end
    end

    // Shift window and track fresh-bit count; non-overlap restarts on a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window <= '0;
            seen   <= '0;
        end else if (cfg_load) begin
            window <= '0;
            seen   <= '0;
        end else if (accept) begin
            window <= nwin;
            if (mode_q == MODE_NONOVERLAP && cnt_inc)
                seen <= '0;
            else
                seen <= nseen;
        end
    end

    // One-cycle match pulse, registered so din never reaches an output directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            match <= 1'b0;
        else
            match <= cnt_inc;
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cfg_load | clr),
        .cnt   (N),
        .sat   (sat)
    );

endmodule

// File: tb/tb_string_detector_param.sv
// Bench for string_detector_param: directed scenarios plus random traffic,
// checked against a bit-history reference model.
module tb_string_detector_param;
    import string_det_pkg::*;

    localparam int PAT_W = 8;
    localparam int CNT_W = 4;
    localparam int LEN_W = $clog2(PAT_W+1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk, rst_n, cfg_load, cfg_mode, in_valid, din, clr;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             match, sat, cfg_err;
    logic [CNT_W-1:0] N;

    int tests = 0;
    int fails = 0;

    // Reference model: received bits since last restart, plus config.
    bit               hist[$];
    logic [PAT_W-1:0] m_pat;
    int               m_len, m_n;
    bit               m_mode, m_sat, m_match, m_err;

    string_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_mode(cfg_mode), .in_valid(in_valid), .din(din),
        .clr(clr), .match(match), .N(N), .sat(sat), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_pat = '0; m_len = PAT_W; m_mode = 1'b0;
        m_n = 0; m_sat = 1'b0; m_match = 1'b0; m_err = 1'b0;
    endtask

    // Last m_len received bits equal the pattern, oldest bit = pattern[m_len-1].
    function automatic bit m_hit();
        int s = hist.size();
        if (s < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++)
            if (hist[s-m_len+i] != m_pat[m_len-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".match"}, match, m_match);
        chk({tag, ".N"}, N, m_n);
        chk({tag, ".sat"}, sat, m_sat);
        chk({tag, ".cfg_err"}, cfg_err, m_err);
    endtask

    // One clock: drive inputs, advance model, check outputs just after the edge.
    task automatic cyc(input bit ld, input logic [PAT_W-1:0] p, input int l,
                       input bit md, input bit v, input bit d, input bit c);
        bit h;
        int lv;
        cfg_load = ld; cfg_pattern = p; cfg_len = LEN_W'(l); cfg_mode = md;
        in_valid = v; din = d; clr = c;
        @(posedge clk);
        lv = int'(cfg_len);
        if (ld) begin
            m_err  = (lv == 0 || lv > PAT_W);
            m_len  = m_err ? PAT_W : lv;
            m_pat  = p;
            m_mode = md;
            hist.delete();
            m_n = 0; m_sat = 1'b0; m_match = 1'b0;
        end else begin
            h = 1'b0;
            if (v) begin
                hist.push_back(d);
                if (hist.size() > PAT_W) void'(hist.pop_front());
                h = m_hit();
            end
            if (c) begin
                m_n = 0; m_sat = 1'b0; m_match = 1'b0;
            end else begin
                m_match = h;
                if (h) begin
                    if (m_n == CMAX) m_sat = 1'b1;
                    else m_n++;
                    if (m_mode == MODE_NONOVERLAP) hist.delete();
                end
            end
        end
        #1;
        check_all("cyc");
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input int l, input bit md);
        cyc(1'b1, p, l, md, 1'b0, 1'b0, 1'b0);
        chk("load.pat_masked", 32'(p & PAT_W'(len_mask(32'(l)))), 32'(m_pat & PAT_W'(len_mask(32'(m_len)))));
    endtask

    task automatic send(input bit d);
        cyc(1'b0, '0, 0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_vec(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send(bits[i]);
    endtask

    initial begin
        cfg_load = 0; cfg_pattern = '0; cfg_len = '0; cfg_mode = 0;
        in_valid = 0; din = 0; clr = 0; rst_n = 0;
        model_reset();
        #12;
        check_all("reset");
        #1 rst_n = 1;

        // Overlap basic: 0110 in 01100110
        load(8'b0110, 4, 1'b0);
        send_vec(16'b0110, 4);
        chk("ovl_basic.first", match, 1);
        send_vec(16'b0110, 4);
        chk("ovl_basic.N", N, 2);

        // 0101 overlapping vs non-overlapping
        load(8'b0101, 4, 1'b0);
        send_vec(16'b01010101, 8);
        chk("ovl0101.N", N, 3);
        load(8'b0101, 4, 1'b1);
        send_vec(16'b01010101, 8);
        chk("novl0101.N", N, 2);

        // Single-bit pattern with an in_valid gap
        load(8'b1, 1, 1'b0);
        send(1); send(1);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("gap.match", match, 0);
            chk("gap.N", N, 2);
        end
        send(0); send(1);
        chk("gap.Nfinal", N, 3);

        // Saturation
        load(8'b1, 1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            send(1);
            chk("sat.match", match, 1);
            if (i == 15) chk("sat.before", sat, 0);
            if (i == 16) chk("sat.rise", sat, 1);
        end
        chk("sat.N", N, CMAX);
        cyc(1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sat.clrN", N, 0);
        chk("sat.clrsat", sat, 0);

        // cfg_load with bad length beats a completing bit
        load(8'b0110, 4, 1'b0);
        send_vec(16'b011, 3);
        cyc(1'b1, 8'b0110, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("cfgbad.match", match, 0);
        chk("cfgbad.err", cfg_err, 1);
        load(8'b0110, 4, 1'b0);
        chk("cfgok.err", cfg_err, 0);

        // Asynchronous reset mid-pattern
        send_vec(16'b0110, 4);
        send_vec(16'b011, 3);
        #2 rst_n = 0;
        #1 model_reset();
        check_all("async_rst");
        chk("async_rst.N", N, 0);
        #3 rst_n = 1;
        send(0);
        chk("rst.lonebit", match, 0);
        load(8'b0110, 4, 1'b0);
        send_vec(16'b0110, 4);
        chk("rst.fullpat", match, 1);

        // Random traffic against the model
        for (int e = 0; e < 8; e++) begin
            int l;
            l = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) ? 0 : $urandom_range(9, 15))
                                            : $urandom_range(1, 4);
            load(PAT_W'($urandom), l, 1'($urandom));
            for (int k = 0; k < 150; k++) begin
                if ($urandom_range(0, 99) == 0)
                    cyc(1'b1, PAT_W'($urandom), $urandom_range(1, PAT_W), 1'($urandom),
                        1'b1, 1'($urandom), 1'b0);
                else
                    cyc(1'b0, '0, 0, 1'b0, $urandom_range(0, 3) != 0, 1'($urandom),
                        $urandom_range(0, 49) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
